// File: rtl/ysyx_22050612_pkg.sv
// ysyx_22050612_pkg: shared GPR geometry constants used as parameter defaults.
package ysyx_22050612_pkg;
  localparam int GPR_AW = 5;
  localparam int XLEN = 64;
endpackage

// File: rtl/ysyx_22050612_rr_pick.sv
// ysyx_22050612_rr_pick: combinational round-robin picker over a doubled request vector.
module ysyx_22050612_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int PW = $clog2(N);
  localparam int W2 = 2 * N;
  localparam int IW = $clog2(W2);
  logic [W2-1:0] dbl;
  logic [IW-1:0] pos;
  always_comb begin
    // low copy masked below ptr, high copy supplies the wrap-around
    dbl = {req, req} & ~((W2'(1) << ptr) - W2'(1));
    pos = '0;
    for (int i = W2 - 1; i >= 0; i--) pos = dbl[i] ? IW'(i) : pos;
    any = |req;
    gnt_idx = PW'(pos >= IW'(N) ? pos - IW'(N) : pos);
    gnt = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/ysyx_22050612_wbarb.sv
// ysyx_22050612_wbarb: round-robin GPR write-port arbiter with one-cycle write stage.
// Define YSYX_22050612_WBARB_FWD_EN to add staged-write forwarding to the decode read ports.
module ysyx_22050612_wbarb
  import ysyx_22050612_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = GPR_AW,
  parameter int DW = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef YSYX_22050612_WBARB_FWD_EN
  input  logic [AW-1:0]     fwd_rs1,
  input  logic [AW-1:0]     fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DW-1:0]     fwd_data1,
  output logic [DW-1:0]     fwd_data2,
`endif
  output logic              gpr_wen,
  output logic [AW-1:0]     gpr_waddr,
  output logic [DW-1:0]     gpr_wdata
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, gnt_idx;
  logic          any, stg_v, wr;
  logic [AW-1:0] stg_rd;
  logic [DW-1:0] stg_data;
  ysyx_22050612_rr_pick #(.N(NREQ)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(req_ready),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      stg_v <= 1'b0;
      stg_rd <= '0;
      stg_data <= '0;
    end else begin
      stg_v <= any;
      if (any) begin
        ptr <= gnt_idx == PW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
        stg_rd <= req_rd[gnt_idx*AW +: AW];
        stg_data <= req_data[gnt_idx*DW +: DW];
      end
    end
  end
  // reset in the landing cycle discards the staged write
  assign wr = stg_v & (|stg_rd) & ~rst;
  assign gpr_wen = wr;
  assign gpr_waddr = stg_rd;
  assign gpr_wdata = stg_data;
`ifdef YSYX_22050612_WBARB_FWD_EN
  assign fwd_hit1 = wr & (stg_rd == fwd_rs1);
  assign fwd_hit2 = wr & (stg_rd == fwd_rs2);
  assign fwd_data1 = stg_data;
  assign fwd_data2 = stg_data;
`endif
endmodule

// File: tb/tb_ysyx_22050612_wbarb.sv
// tb_ysyx_22050612_wbarb: directed and random checks against a queue-free behavioural arbiter model.
module tb_ysyx_22050612_wbarb;
  localparam int N = 3;
  localparam int AW = 5;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*AW-1:0] req_rd = '0;
  logic [N*DW-1:0] req_data = '0;
  logic gpr_wen;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic [AW-1:0] fwd_rs1 = '0, fwd_rs2 = '0;
`ifdef YSYX_22050612_WBARB_FWD_EN
  logic fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
`endif
  int checks = 0;
  int errors = 0;
  bit pend [N];
  logic [AW-1:0] prd [N];
  logic [DW-1:0] pdat [N];
  int mptr = 0;
  bit ew = 0;
  logic [AW-1:0] ea = '0;
  logic [DW-1:0] ed = '0;
  ysyx_22050612_wbarb #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd(req_rd),
    .req_data(req_data),
`ifdef YSYX_22050612_WBARB_FWD_EN
    .fwd_rs1(fwd_rs1),
    .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1),
    .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2),
`endif
    .gpr_wen(gpr_wen),
    .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    pend[i] = 1;
    prd[i] = rd;
    pdat[i] = d;
  endtask
  // one clock: drive after negedge, check mid-cycle, advance the model at posedge
  task automatic cyc(input bit r);
    int g;
    logic [N-1:0] er;
    bit lw;
    rst = r;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_rd[i*AW +: AW] = prd[i];
      req_data[i*DW +: DW] = pdat[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
    er = g >= 0 ? N'(1) << g : '0;
    lw = ew && !r;
    if (!r) chk("req_ready", 64'(req_ready), 64'(er));
    chk("gpr_wen", 64'(gpr_wen), 64'(lw));
    if (lw) begin
      chk("gpr_waddr", 64'(gpr_waddr), 64'(ea));
      chk("gpr_wdata", gpr_wdata, ed);
    end
`ifdef YSYX_22050612_WBARB_FWD_EN
    chk("fwd_hit1", 64'(fwd_hit1), 64'(lw && ea == fwd_rs1));
    chk("fwd_hit2", 64'(fwd_hit2), 64'(lw && ea == fwd_rs2));
    if (lw) chk("fwd_data1", fwd_data1, ed);
    if (lw) chk("fwd_data2", fwd_data2, ed);
`endif
    @(posedge clk);
    if (r) begin
      mptr = 0;
      ew = 0;
    end else if (g >= 0) begin
      ew = prd[g] != 0;
      ea = prd[g];
      ed = pdat[g];
      pend[g] = 0;
      mptr = (g + 1) % N;
    end else ew = 0;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int k = 0; k < 2 * N; k++) if (pend[0] || pend[1] || pend[2]) cyc(0);
    chk("drained", 64'(pend[0] || pend[1] || pend[2]), 64'(0));
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      prd[i] = '0;
      pdat[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(64'h100 + i));
    cyc(1);
    cyc(1);
    chk("reset_waddr", 64'(gpr_waddr), 64'(0));
    chk("reset_wdata", gpr_wdata, 64'(0));
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, AW'(i + 1), DW'(64'h100 + i));
      cyc(0);
    end
    drain();
    set_req(1, 5'd5, 64'hDEAD_BEEF);
    cyc(0);
    chk("single_wen", 64'(gpr_wen), 64'(1));
    chk("single_waddr", 64'(gpr_waddr), 64'(5));
    chk("single_wdata", gpr_wdata, 64'hDEAD_BEEF);
    set_req(2, 5'd0, 64'h1234);
    cyc(0);
    chk("x0_ptr_wrap", 64'(mptr), 64'(0));
    set_req(0, 5'd7, 64'h77);
    cyc(0);
    cyc(1);
    cyc(0);
`ifdef YSYX_22050612_WBARB_FWD_EN
    set_req(1, 5'd9, 64'h55);
    cyc(0);
    fwd_rs1 = 5'd9;
    fwd_rs2 = 5'd0;
    #1;
    chk("fwd_hit1_dir", 64'(fwd_hit1), 64'(1));
    chk("fwd_data1_dir", fwd_data1, 64'h55);
    chk("fwd_hit2_dir", 64'(fwd_hit2), 64'(0));
    @(negedge clk);
    ew = 0;
`endif
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1)
          set_req(i, $urandom_range(3, 0) == 0 ? 5'd0 : AW'($urandom), {$urandom, $urandom});
      fwd_rs1 = $urandom_range(1, 0) == 1 ? ea : AW'($urandom);
      fwd_rs2 = AW'($urandom);
      cyc($urandom_range(39, 0) == 0);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_wbarb.md
# ysyx_22050612_wbarb

Round-robin arbiter and write-stage register for the single GPR write port of the register file. Sits between the execution-side producers (ALU result, LSU load return, multi-cycle MUL/DIV result) and the register file write port. Grants at most one producer per cycle and presents the winner to the register file one cycle later. Optionally forwards the staged write to the decode read ports.

## Interface
- NREQ, 3, number of write requesters (2..8)
- AW, 5, register address width
- DW, 64, register data width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant, combinational, one-hot or zero
- req_rd  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- gpr_wen  out  1  register file write enable
- gpr_waddr  out  AW  register file write address
- gpr_wdata  out  DW  register file write data
- fwd_rs1, fwd_rs2  in  AW each  decode read addresses (only with WBARB_FWD_EN)
- fwd_hit1, fwd_hit2  out  1 each  staged write matches read address (only with WBARB_FWD_EN)
- fwd_data1, fwd_data2  out  DW each  staged write data (only with WBARB_FWD_EN)

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i]. Once req_valid[i] is high, req_rd and req_data of requester i stay stable, and valid stays high, until the transfer completes.
- Arbitration: round-robin pointer ptr in 0..NREQ-1. Search starts at ptr and proceeds upward modulo NREQ. The first valid requester is granted.
- After a grant to requester g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- At most one req_ready bit is high. req_ready is 0 for every requester when no requester is valid.
- Stage register: {stg_v, stg_rd, stg_data}. It loads the granted request every cycle and loads stg_v=0 when there is no grant.
- The stage is never back-pressured. The register file accepts one write per cycle.
- gpr_wen = stg_v & (stg_rd != 0). gpr_waddr = stg_rd. gpr_wdata = stg_data.
- A write to x0 is granted and consumed, and ptr advances, but no write is issued.
- Simultaneous requests: only one is granted per cycle. Losers keep valid and are granted on later cycles. No requester waits more than NREQ-1 cycles.

## Timing
- Grant is combinational: ready is asserted in the same cycle valid is seen (cycle t).
- Register file write is issued in cycle t+1, so write latency is 1 cycle.
- Back-to-back grants are allowed every cycle. Throughput is 1 write per cycle.
- Reset values: ptr=0, stg_v=0, stg_rd=0, stg_data=0. Consequently gpr_wen=0, gpr_waddr=0, gpr_wdata=0, and req_ready follows the inputs from ptr=0.
- Reset mid-operation: a staged write is discarded in the reset cycle, so no write is issued in the following cycle. Requests still held after reset are re-arbitrated starting from requester 0.
- req_ready during a reset cycle is don't-care. Requesters ignore handshakes while rst is high.

## Configuration
- Macro: YSYX_22050612_WBARB_FWD_EN.
- Defined:
  - fwd_* ports exist.
  - fwd_hitN = stg_v & (stg_rd != 0) & (stg_rd == fwd_rsN).
  - fwd_dataN = stg_data.
  - Both outputs are combinational and cover the write landing this cycle.
- Undefined:
  - fwd_* ports are absent.
  - The decode path relies on register file write-before-read.

## Structure
- Shared package ysyx_22050612_pkg holds the GPR_AW=5 and XLEN=64 constants that serve as parameter defaults.
- Sub-module ysyx_22050612_rr_pick(N): combinational round-robin picker.
  - Inputs: req[N] and ptr.
  - Outputs: one-hot gnt[N], gnt_idx, any.
  - Implemented with a doubled request vector and a priority mask.
- Top level holds ptr, the stage register and the optional forwarding compare.

## Test plan
- Reset: hold rst 2 cycles with all req_valid=1, then release. Cycle after release: gpr_wen=0. First grant goes to req 0; ptr becomes 1.
- Single requester: req1 valid, rd=5, data=0xDEAD_BEEF. Same cycle: ready[1]=1. Next cycle: gpr_wen=1, waddr=5, wdata=0xDEAD_BEEF.
- Contention: all 3 valid continuously with distinct rd 1/2/3, starting from ptr=0. Grants run 0,1,2,0; writes to x1,x2,x3,x1 on consecutive cycles.
- x0 write: req2 valid with rd=0, data=0x1234. ready[2]=1, next cycle gpr_wen=0, ptr advances to 0.
- Mid-operation reset: grant req0 (rd=7) in cycle t and assert rst in cycle t+1. No write to x7 occurs, and ptr=0 afterwards.
- With YSYX_22050612_WBARB_FWD_EN: stage rd=9, data=0x55, fwd_rs1=9, fwd_rs2=0. Result: fwd_hit1=1, fwd_data1=0x55, fwd_hit2=0.
